// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between instruction fetch and load/store
// traffic in front of a single data-memory port. One transaction at a time:
// accept -> (REQ -> WAIT) or straight to an error response -> RESP -> IDLE.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [1:0]        lsu_wen,
    input  logic [1:0]        lsu_ren,
    input  logic              lsu_unsign,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [1:0]        mem_wen,
    output logic [1:0]        mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic       OWN_IFU   = 1'b0;
    localparam logic       OWN_LSU   = 1'b1;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t              state_reg, state_next;
    logic                last_grant_reg;
    logic                owner_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [1:0]          wen_reg, ren_reg;
    logic                unsign_reg;
    logic [7:0]          cnt_reg;
    logic                mem_req_valid_reg;
    logic                ifu_resp_valid_reg, lsu_resp_valid_reg;
    logic                ifu_err_reg, lsu_err_reg;
    logic [DATA_W-1:0]   ifu_rdata_reg, lsu_rdata_reg;

    logic                grant_lsu, grant_ifu, accept;
    logic [1:0]          sel_wen, sel_ren, sel_len;
    logic                sel_unsign;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                req_err;
    logic                wait_timeout;
    logic [DATA_W-1:0]   ext_rdata;
    logic                resp_fire, resp_owner, resp_err_next;
    logic [DATA_W-1:0]   resp_rdata_next;
    logic                mem_req_valid_next;

    // Round-robin choice and selection of the candidate request fields
    always_comb begin
        grant_lsu  = lsu_req_valid && (!ifu_req_valid || last_grant_reg == OWN_IFU);
        grant_ifu  = ifu_req_valid && !grant_lsu;
        accept     = (state_reg == IDLE) && (grant_lsu || grant_ifu);
        sel_wen    = grant_lsu ? lsu_wen    : 2'b00;
        sel_ren    = grant_lsu ? lsu_ren    : 2'b11;
        sel_unsign = grant_lsu ? lsu_unsign : 1'b0;
        sel_addr   = grant_lsu ? lsu_addr   : ifu_addr;
        sel_wdata  = grant_lsu ? lsu_wdata  : '0;
        sel_len    = (sel_wen != 2'b00) ? sel_wen : sel_ren;
        req_err    = ((sel_wen == 2'b00) == (sel_ren == 2'b00))
                  || (sel_len == 2'b10 && sel_addr[0])
                  || (sel_len == 2'b11 && sel_addr[1:0] != 2'b00);
        wait_timeout = (cnt_reg == TIMEOUT_C);
    end

    // Sign/zero extension of raw memory data according to the latched read length
    always_comb begin
        ext_rdata = '0;
        case (ren_reg)
            2'b01:   ext_rdata = {{(DATA_W-8){mem_rdata[7] & ~unsign_reg}}, mem_rdata[7:0]};
            2'b10:   ext_rdata = {{(DATA_W-16){mem_rdata[15] & ~unsign_reg}}, mem_rdata[15:0]};
            2'b11:   ext_rdata = mem_rdata;
            default: ext_rdata = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = req_err ? RESP : REQ;
            REQ:  if (mem_req_ready) state_next = WAIT;
            WAIT: if (mem_resp_valid || wait_timeout) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: ready strobes plus next values for the registered outputs
    always_comb begin
        ifu_req_ready      = (state_reg == IDLE) && grant_ifu;
        lsu_req_ready      = (state_reg == IDLE) && grant_lsu;
        resp_fire          = 1'b0;
        resp_owner         = owner_reg;
        resp_err_next      = 1'b0;
        resp_rdata_next    = '0;
        mem_req_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                resp_owner = grant_lsu;
                if (accept && req_err) begin
                    resp_fire     = 1'b1;
                    resp_err_next = 1'b1;
                end
                mem_req_valid_next = accept && !req_err;
            end
            REQ:  mem_req_valid_next = !mem_req_ready;
            WAIT: begin
                // A response in the same cycle as the timeout still wins
                if (mem_resp_valid) begin
                    resp_fire       = 1'b1;
                    resp_rdata_next = (ren_reg != 2'b00) ? ext_rdata : '0;
                end else if (wait_timeout) begin
                    resp_fire     = 1'b1;
                    resp_err_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request latch, timeout counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg     <= OWN_IFU;
            owner_reg          <= OWN_IFU;
            addr_reg           <= '0;
            wdata_reg          <= '0;
            wen_reg            <= 2'b00;
            ren_reg            <= 2'b00;
            unsign_reg         <= 1'b0;
            cnt_reg            <= 8'd0;
            mem_req_valid_reg  <= 1'b0;
            ifu_resp_valid_reg <= 1'b0;
            lsu_resp_valid_reg <= 1'b0;
            ifu_err_reg        <= 1'b0;
            lsu_err_reg        <= 1'b0;
            ifu_rdata_reg      <= '0;
            lsu_rdata_reg      <= '0;
        end else begin
            if (accept) begin
                last_grant_reg <= grant_lsu;
                owner_reg      <= grant_lsu;
                addr_reg       <= sel_addr;
                wdata_reg      <= sel_wdata;
                wen_reg        <= sel_wen;
                ren_reg        <= sel_ren;
                unsign_reg     <= sel_unsign;
            end
            if (state_reg == REQ)       cnt_reg <= 8'd0;
            else if (state_reg == WAIT) cnt_reg <= cnt_reg + 8'd1;
            mem_req_valid_reg  <= mem_req_valid_next;
            ifu_resp_valid_reg <= resp_fire && (resp_owner == OWN_IFU);
            lsu_resp_valid_reg <= resp_fire && (resp_owner == OWN_LSU);
            ifu_err_reg        <= resp_fire && (resp_owner == OWN_IFU) && resp_err_next;
            lsu_err_reg        <= resp_fire && (resp_owner == OWN_LSU) && resp_err_next;
            ifu_rdata_reg      <= (resp_fire && resp_owner == OWN_IFU) ? resp_rdata_next : '0;
            lsu_rdata_reg      <= (resp_fire && resp_owner == OWN_LSU) ? resp_rdata_next : '0;
        end
    end

    assign mem_req_valid  = mem_req_valid_reg;
    assign mem_wen        = wen_reg;
    assign mem_ren        = ren_reg;
    assign mem_addr       = addr_reg;
    assign mem_wdata      = wdata_reg;
    assign ifu_resp_valid = ifu_resp_valid_reg;
    assign ifu_rdata      = ifu_rdata_reg;
    assign ifu_err        = ifu_err_reg;
    assign lsu_resp_valid = lsu_resp_valid_reg;
    assign lsu_rdata      = lsu_rdata_reg;
    assign lsu_err        = lsu_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small zero-wait memory responder.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_unsign, lsu_resp_valid, lsu_err;
    logic [1:0]  lsu_wen, lsu_ren;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [1:0]  mem_wen, mem_ren;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        mem_auto;        // responder answers one cycle after each handshake
    logic        mem_resp_auto = 1'b0;
    logic        mem_resp_force;  // manual (stale) responses
    int          mem_req_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    assign mem_resp_valid = mem_resp_auto | mem_resp_force;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_wen(lsu_wen), .lsu_ren(lsu_ren), .lsu_unsign(lsu_unsign),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    // Memory model: counts accepted requests and answers with zero wait when enabled
    always @(posedge clk) begin
        mem_resp_auto <= mem_auto && mem_req_valid && mem_req_ready;
        if (mem_req_valid && mem_req_ready) mem_req_cnt <= mem_req_cnt + 1;
    end

    // Runs one LSU transaction and reports what came back; starts and ends at posedge+1
    task automatic run_lsu(input logic [1:0] wen, input logic [1:0] ren, input logic uns,
                           input logic [31:0] addr, input logic [31:0] raw,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int nreq);
        int start;
        start = mem_req_cnt;
        mem_rdata = raw;
        lsu_wen = wen; lsu_ren = ren; lsu_unsign = uns; lsu_addr = addr;
        lsu_wdata = 32'hA5A5_5A5A; lsu_req_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !lsu_req_ready; i++) begin
            @(posedge clk); #2;
        end
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        lat = 1;
        while (!lsu_resp_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = lsu_rdata;
        err   = lsu_err;
        if (!lsu_resp_valid) begin
            err = 1'bx;
            lat = -1;
        end
        nreq = mem_req_cnt - start;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_req_valid got %b want 0", mem_req_valid); end
        tests++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b%b want 00", ifu_resp_valid, lsu_resp_valid); end
        tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_fields got %h/%h want 0/0", mem_addr, mem_wdata); end
        tests++; if (mem_wen !== 2'b00 || mem_ren !== 2'b00) begin fails++; $display("FAIL reset_mem_len got %b/%b want 00/00", mem_wen, mem_ren); end
        tests++; if (ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0 || ifu_err !== 1'b0 || lsu_err !== 1'b0) begin fails++; $display("FAIL reset_rdata_err got %h %h %b %b want zeros", ifu_rdata, lsu_rdata, ifu_err, lsu_err); end
        tests++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b%b want 00", ifu_req_ready, lsu_req_ready); end
    endtask

    task automatic test_ifu_fetch;
        int lsu_pulses;
        lsu_pulses = 0;
        mem_rdata = 32'hDEAD_BEEF;
        ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1;
        #1;
        tests++; if (ifu_req_ready !== 1'b1) begin fails++; $display("FAIL ifu_ready_c0 got %b want 1", ifu_req_ready); end
        @(posedge clk); #1; ifu_req_valid = 1'b0;
        tests++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_ren !== 2'b11 || mem_wen !== 2'b00)
            begin fails++; $display("FAIL ifu_mem_req_c1 got v=%b a=%h r=%b w=%b want 1/80000000/11/00", mem_req_valid, mem_addr, mem_ren, mem_wen); end
        @(posedge clk); #1;
        tests++; if (ifu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin fails++; $display("FAIL ifu_c2_quiet got resp=%b req=%b want 0/0", ifu_resp_valid, mem_req_valid); end
        if (lsu_resp_valid) lsu_pulses++;
        @(posedge clk); #1;
        tests++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'hDEAD_BEEF || ifu_err !== 1'b0)
            begin fails++; $display("FAIL ifu_resp_c3 got v=%b d=%h e=%b want 1/deadbeef/0", ifu_resp_valid, ifu_rdata, ifu_err); end
        if (lsu_resp_valid) lsu_pulses++;
        @(posedge clk); #1;
        tests++; if (ifu_resp_valid !== 1'b0 || ifu_rdata !== 32'h0) begin fails++; $display("FAIL ifu_resp_c4_clear got v=%b d=%h want 0/0", ifu_resp_valid, ifu_rdata); end
        tests++; if (lsu_pulses != 0) begin fails++; $display("FAIL ifu_no_lsu_pulse got %0d want 0", lsu_pulses); end
    endtask

    task automatic test_round_robin;
        logic [3:0] seq;   // 1 = LSU granted
        int         n;
        int         both;
        n = 0; both = 0; seq = 4'b0;
        apply_reset();
        mem_rdata = 32'h1111_2222;
        ifu_addr = 32'h8000_0100; ifu_req_valid = 1'b1;
        lsu_wen = 2'b00; lsu_ren = 2'b11; lsu_unsign = 1'b0; lsu_addr = 32'h8000_0200;
        lsu_req_valid = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            if (ifu_req_ready && lsu_req_ready) both++;
            if (ifu_req_ready || lsu_req_ready) begin
                seq[n] = lsu_req_ready;
                n++;
            end
            @(posedge clk); #1;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++; if (n != 4) begin fails++; $display("FAIL rr_grant_count got %0d want 4", n); end
        tests++; if (seq !== 4'b0101) begin fails++; $display("FAIL rr_sequence got %b want 0101 (bit0 first, 1=LSU)", seq); end
        tests++; if (both != 0) begin fails++; $display("FAIL rr_dual_ready got %0d want 0", both); end
    endtask

    task automatic test_load_ext;
        logic [31:0] d; logic e; int lat, nreq;
        run_lsu(2'b00, 2'b01, 1'b0, 32'h8000_0001, 32'h0000_00F0, d, e, lat, nreq);
        tests++; if (d !== 32'hFFFF_FFF0 || e !== 1'b0 || lat != 3) begin fails++; $display("FAIL lb_signed got d=%h e=%b lat=%0d want ffffff f0/0/3", d, e, lat); end
        run_lsu(2'b00, 2'b01, 1'b1, 32'h8000_0003, 32'h0000_00F0, d, e, lat, nreq);
        tests++; if (d !== 32'h0000_00F0 || e !== 1'b0) begin fails++; $display("FAIL lb_unsigned got d=%h e=%b want 000000f0/0", d, e); end
        run_lsu(2'b00, 2'b10, 1'b0, 32'h8000_0002, 32'h0000_8001, d, e, lat, nreq);
        tests++; if (d !== 32'hFFFF_8001 || e !== 1'b0) begin fails++; $display("FAIL lh_signed got d=%h e=%b want ffff8001/0", d, e); end
        run_lsu(2'b00, 2'b10, 1'b1, 32'h8000_0002, 32'h1234_8001, d, e, lat, nreq);
        tests++; if (d !== 32'h0000_8001) begin fails++; $display("FAIL lh_unsigned got d=%h want 00008001", d); end
        run_lsu(2'b00, 2'b11, 1'b0, 32'h8000_0004, 32'h8765_4321, d, e, lat, nreq);
        tests++; if (d !== 32'h8765_4321 || e !== 1'b0 || nreq != 1) begin fails++; $display("FAIL lw_pass got d=%h e=%b nreq=%0d want 87654321/0/1", d, e, nreq); end
        run_lsu(2'b11, 2'b00, 1'b0, 32'h8000_0008, 32'hFFFF_FFFF, d, e, lat, nreq);
        tests++; if (d !== 32'h0 || e !== 1'b0 || nreq != 1 || lat != 3) begin fails++; $display("FAIL sw_ack got d=%h e=%b nreq=%0d lat=%0d want 0/0/1/3", d, e, nreq, lat); end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic e; int lat, nreq;
        run_lsu(2'b10, 2'b00, 1'b0, 32'h8000_0003, 32'h0, d, e, lat, nreq);
        tests++; if (e !== 1'b1 || d !== 32'h0 || lat != 1 || nreq != 0) begin fails++; $display("FAIL sh_misaligned got e=%b d=%h lat=%0d nreq=%0d want 1/0/1/0", e, d, lat, nreq); end
        run_lsu(2'b01, 2'b01, 1'b0, 32'h8000_0000, 32'h0, d, e, lat, nreq);
        tests++; if (e !== 1'b1 || nreq != 0) begin fails++; $display("FAIL both_lengths got e=%b nreq=%0d want 1/0", e, nreq); end
        run_lsu(2'b00, 2'b00, 1'b0, 32'h8000_0000, 32'h0, d, e, lat, nreq);
        tests++; if (e !== 1'b1 || nreq != 0) begin fails++; $display("FAIL no_length got e=%b nreq=%0d want 1/0", e, nreq); end
        run_lsu(2'b00, 2'b11, 1'b0, 32'h8000_0002, 32'h5555_5555, d, e, lat, nreq);
        tests++; if (e !== 1'b1 || d !== 32'h0 || nreq != 0) begin fails++; $display("FAIL lw_misaligned got e=%b d=%h nreq=%0d want 1/0/0", e, d, nreq); end
        // Misaligned fetch: error pulse on the IFU side one cycle after accept
        ifu_addr = 32'h8000_0002; ifu_req_valid = 1'b1;
        @(posedge clk); #1; ifu_req_valid = 1'b0;
        tests++; if (ifu_resp_valid !== 1'b1 || ifu_err !== 1'b1 || ifu_rdata !== 32'h0 || mem_req_valid !== 1'b0 || lsu_resp_valid !== 1'b0)
            begin fails++; $display("FAIL ifu_misaligned got v=%b e=%b d=%h mreq=%b lv=%b want 1/1/0/0/0", ifu_resp_valid, ifu_err, ifu_rdata, mem_req_valid, lsu_resp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        logic [31:0] d; logic e; int lat, nreq; int pulses;
        mem_auto = 1'b0;
        run_lsu(2'b00, 2'b11, 1'b0, 32'h8000_0010, 32'h7777_7777, d, e, lat, nreq);
        tests++; if (e !== 1'b1 || d !== 32'h0 || lat != 258) begin fails++; $display("FAIL timeout got e=%b d=%h lat=%0d want 1/0/258", e, d, lat); end
        // Late response while idle must not produce anything
        pulses = 0;
        mem_resp_force = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (lsu_resp_valid || ifu_resp_valid) pulses++;
        end
        mem_resp_force = 1'b0;
        @(posedge clk); #1;
        if (lsu_resp_valid || ifu_resp_valid) pulses++;
        tests++; if (pulses != 0) begin fails++; $display("FAIL late_resp_ignored got %0d pulses want 0", pulses); end
        mem_auto = 1'b1;
        run_lsu(2'b00, 2'b10, 1'b0, 32'h8000_0012, 32'h0000_7FFE, d, e, lat, nreq);
        tests++; if (d !== 32'h0000_7FFE || e !== 1'b0 || lat != 3) begin fails++; $display("FAIL after_timeout got d=%h e=%b lat=%0d want 00007ffe/0/3", d, e, lat); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] d; logic e; int lat, nreq; int pulses;
        pulses = 0;
        mem_auto = 1'b0;
        mem_rdata = 32'hCAFE_F00D;
        lsu_wen = 2'b00; lsu_ren = 2'b11; lsu_unsign = 1'b0; lsu_addr = 32'h8000_0020;
        lsu_req_valid = 1'b1;
        @(posedge clk); #1; lsu_req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (lsu_resp_valid) pulses++;
        end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        tests++; if (mem_req_valid !== 1'b0 || mem_addr !== 32'h0 || mem_ren !== 2'b00 || lsu_resp_valid !== 1'b0 || lsu_rdata !== 32'h0 || lsu_err !== 1'b0)
            begin fails++; $display("FAIL abort_reset_vals got mv=%b a=%h r=%b lv=%b d=%h e=%b want all 0", mem_req_valid, mem_addr, mem_ren, lsu_resp_valid, lsu_rdata, lsu_err); end
        mem_resp_force = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (lsu_resp_valid || ifu_resp_valid) pulses++;
        end
        mem_resp_force = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (lsu_resp_valid || ifu_resp_valid) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL abort_no_resp got %0d pulses want 0", pulses); end
        mem_auto = 1'b1;
        run_lsu(2'b00, 2'b01, 1'b1, 32'h8000_0021, 32'hFFFF_FF55, d, e, lat, nreq);
        tests++; if (d !== 32'h0000_0055 || e !== 1'b0 || lat != 3) begin fails++; $display("FAIL after_abort got d=%h e=%b lat=%0d want 00000055/0/3", d, e, lat); end
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_wen = 2'b00; lsu_ren = 2'b00; lsu_unsign = 1'b0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
        mem_req_ready = 1'b1; mem_rdata = 32'h0; mem_auto = 1'b1; mem_resp_force = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_ifu_fetch();
        test_round_robin();
        test_load_ext();
        test_errors();
        test_timeout();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop so a wedged run still ends with a visible failure
    initial begin
        #200000;
        $display("FAIL global_timeout got still running want finished");
        $fatal(1, "simulation time limit");
    end

endmodule
